layer_sequencer: RTL
====================

Name: layer_sequencer

Overview:
- Program-fetch stage directly downstream of the instruction RAM.
- Walks the layer-size program from address 0 until it reads the END_OF_PROGRAM word. The program is a list of neuron counts per layer, e.g. 8,5,3,FF.
- For each adjacent pair of sizes it issues one layer command {in_size, out_size, index} to the network compute engine over a valid/ready handshake.
- Reports done, or error with a cause code.

Parameters:
- ADDR_WIDTH, 8, instruction RAM address width.
- DATA_WIDTH, 8, instruction word / layer-size width.
- END_OF_PROGRAM, 8'hFF, program terminator word.
- PROG_DEPTH, 5, number of RAM words; the highest legal address is PROG_DEPTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run the program; sampled only in IDLE, DONE or ERROR.
- ram_addr  out  ADDR_WIDTH  address to the instruction RAM (registered program counter).
- ram_en  out  1  RAM read enable; high only in FETCH_IN and FETCH_OUT.
- ram_data  in  DATA_WIDTH  RAM read data; combinational from addr/en, captured at the clock edge that ends a FETCH state.
- layer_valid  out  1  layer command valid.
- layer_ready  in  1  compute engine accepts the command.
- layer_in_size  out  DATA_WIDTH  input neuron count of the layer.
- layer_out_size  out  DATA_WIDTH  output neuron count of the layer.
- layer_idx  out  ADDR_WIDTH  zero-based layer index.
- layer_count  out  ADDR_WIDTH  number of commands accepted in the current or last run.
- busy  out  1  high in FETCH_IN, FETCH_OUT and ISSUE.
- done  out  1  one-cycle pulse at successful completion.
- error  out  1  sticky error flag.
- err_code  out  2  error cause, meaningful only while error=1:
  - 00 zero layer size
  - 01 empty program
  - 10 no layers (single size)
  - 11 address overflow

Behaviour:
- Reset (asynchronous, any state, including mid-run):
  - state=IDLE, pc=0.
  - All outputs 0: ram_addr, ram_en, layer_valid, layer_in_size, layer_out_size, layer_idx, layer_count, busy, done, error, err_code.
- States: IDLE, FETCH_IN, FETCH_OUT, ISSUE, DONE, ERROR.
- IDLE / DONE / ERROR, start=1:
  - pc<=0, layer_idx<=0, layer_count<=0, error<=0, err_code<=0.
  - Next state FETCH_IN.
  - start in any other state is ignored.
- FETCH_IN (ram_en=1, ram_addr=pc), at the edge:
  - data==END_OF_PROGRAM -> ERROR, code 01.
  - data==0 -> ERROR, code 00.
  - otherwise prev_size<=data, pc<=pc+1, go to FETCH_OUT.
- FETCH_OUT (ram_en=1, ram_addr=pc), at the edge:
  - data==END_OF_PROGRAM: go to ERROR code 10 if layer_count==0, else go to DONE.
  - data==0 -> ERROR, code 00.
  - otherwise cur_size<=data, pc<=pc+1, go to ISSUE.
- Overflow check:
  - Before entering FETCH_OUT, if the incremented pc equals PROG_DEPTH, go to ERROR code 11 instead.
  - The RAM is never driven with an address ≥ PROG_DEPTH.
- ISSUE:
  - layer_valid=1; layer_in_size=prev_size, layer_out_size=cur_size, layer_idx held stable.
  - Payload must not change while valid=1 and ready=0; valid is never withdrawn without acceptance.
  - On valid&ready: prev_size<=cur_size, layer_idx<=layer_idx+1, layer_count<=layer_count+1, go to FETCH_OUT (subject to the overflow check).
- DONE: done=1 for exactly this cycle; next state IDLE unless start=1.
- ERROR: error=1 and err_code held until start or reset; ram_en=0, layer_valid=0.
- Latency: start sampled at edge N puts FETCH_IN in cycle N+1; the first layer_valid appears in cycle N+3.
- Each further layer takes 2 cycles with layer_ready held high: 1 ISSUE cycle plus 1 FETCH_OUT cycle.
- No arithmetic is performed on sizes; pc and index increment wrap-free (bounded by the overflow check).

Test Plan:
- Program 8,5,3,FF,FF, layer_ready tied 1, start at cycle 0:
  - layer_valid in cycle 3 with (8,5,idx0), and in cycle 5 with (5,3,idx1).
  - done pulse in cycle 7; layer_count=2; error=0.
- Same program, layer_ready low for 4 cycles on the first command:
  - layer_valid and the (8,5,0) payload are held stable.
  - Sequence resumes on ready; final layer_count=2.
- Program FF,...: error=1, err_code=01 in cycle 2; layer_valid never asserted.
- Program 8,FF: error=1, err_code=10. Program 8,0,...: err_code=00.
- Program 8,5,3,4,2 (no terminator): 4 commands issued, then error=1, err_code=11; ram_addr never equals 5.
- rst_n pulsed low during ISSUE:
  - All outputs are 0 immediately (asynchronously).
  - After release, start reruns the 8,5,3 program from address 0 correctly.
  - start asserted while busy has no effect.

Source files
------------

// File: rtl/layer_sequencer_if.sv
// Bundle between the layer sequencer, the instruction RAM it reads and the
// compute engine it feeds with layer commands. The master side is the
// sequencer; the slave side is the RAM plus engine environment.
interface layer_sequencer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_en;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  layer_valid;
    logic                  layer_ready;
    logic [DATA_WIDTH-1:0] layer_in_size;
    logic [DATA_WIDTH-1:0] layer_out_size;
    logic [ADDR_WIDTH-1:0] layer_idx;

    modport master (
        output ram_addr,
        output ram_en,
        input  ram_data,
        output layer_valid,
        input  layer_ready,
        output layer_in_size,
        output layer_out_size,
        output layer_idx
    );

    modport slave (
        input  ram_addr,
        input  ram_en,
        output ram_data,
        input  layer_valid,
        output layer_ready,
        input  layer_in_size,
        input  layer_out_size,
        input  layer_idx
    );
endinterface

// File: rtl/layer_sequencer.sv
// Layer sequencer: walks the layer-size program in the instruction RAM from
// address 0 and, for every adjacent pair of sizes, hands one layer command
// {in_size, out_size, index} to the compute engine over valid/ready.
// The program counter carries one extra bit so the "one past the last legal
// address" value can be represented and compared without wrapping; the RAM
// only ever sees the counter while a fetch is in progress.
module layer_sequencer #(
    parameter int                   ADDR_WIDTH     = 8,
    parameter int                   DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] END_OF_PROGRAM = 8'hFF,
    parameter int                   PROG_DEPTH     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    layer_sequencer_if.master     bus,
    output logic [ADDR_WIDTH-1:0] layer_count,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] PC_LIMIT = PW'(PROG_DEPTH);

    localparam logic [1:0] ERR_ZERO_SIZE = 2'b00;
    localparam logic [1:0] ERR_EMPTY     = 2'b01;
    localparam logic [1:0] ERR_NO_LAYERS = 2'b10;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_IN,
        S_FETCH_OUT,
        S_ISSUE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [PW-1:0]         pc;
    logic [PW-1:0]         pc_inc;
    logic [DATA_WIDTH-1:0] prev_size;
    logic [DATA_WIDTH-1:0] cur_size;
    logic [ADDR_WIDTH-1:0] idx_q;

    logic                  clr_run;
    logic                  load_prev;
    logic                  load_cur;
    logic                  adv_pc;
    logic                  accept;
    logic                  set_err;
    logic [1:0]            err_next;

    logic                  data_is_eop;
    logic                  data_is_zero;

    assign pc_inc       = pc + PW'(1);
    assign data_is_eop  = (bus.ram_data == END_OF_PROGRAM);
    assign data_is_zero = (bus.ram_data == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision and the datapath strobes that go with each transition.
    always_comb begin
        state_next = state;
        clr_run    = 1'b0;
        load_prev  = 1'b0;
        load_cur   = 1'b0;
        adv_pc     = 1'b0;
        accept     = 1'b0;
        set_err    = 1'b0;
        err_next   = ERR_ZERO_SIZE;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    clr_run    = 1'b1;
                    state_next = S_FETCH_IN;
                end else if (state == S_DONE) begin
                    state_next = S_IDLE;
                end
            end
            S_FETCH_IN: begin
                if (data_is_eop) begin
                    set_err  = 1'b1;
                    err_next = ERR_EMPTY;
                end else if (data_is_zero) begin
                    set_err  = 1'b1;
                    err_next = ERR_ZERO_SIZE;
                end else if (pc_inc == PC_LIMIT) begin
                    set_err  = 1'b1;
                    err_next = ERR_OVERFLOW;
                end else begin
                    load_prev  = 1'b1;
                    adv_pc     = 1'b1;
                    state_next = S_FETCH_OUT;
                end
            end
            S_FETCH_OUT: begin
                if (data_is_eop) begin
                    if (layer_count == '0) begin
                        set_err  = 1'b1;
                        err_next = ERR_NO_LAYERS;
                    end else begin
                        state_next = S_DONE;
                    end
                end else if (data_is_zero) begin
                    set_err  = 1'b1;
                    err_next = ERR_ZERO_SIZE;
                end else begin
                    load_cur   = 1'b1;
                    adv_pc     = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.layer_ready) begin
                    accept = 1'b1;
                    if (pc == PC_LIMIT) begin
                        set_err  = 1'b1;
                        err_next = ERR_OVERFLOW;
                    end else begin
                        state_next = S_FETCH_OUT;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (set_err) begin
            state_next = S_ERROR;
        end
    end

    // Program counter, layer sizes, command index/count and the error cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            prev_size   <= '0;
            cur_size    <= '0;
            idx_q       <= '0;
            layer_count <= '0;
            err_code    <= '0;
        end else begin
            if (clr_run) begin
                pc          <= '0;
                idx_q       <= '0;
                layer_count <= '0;
                err_code    <= '0;
            end
            if (adv_pc) begin
                pc <= pc_inc;
            end
            if (load_prev) begin
                prev_size <= bus.ram_data;
            end
            if (load_cur) begin
                cur_size <= bus.ram_data;
            end
            if (accept) begin
                prev_size   <= cur_size;
                idx_q       <= idx_q + ADDR_WIDTH'(1);
                layer_count <= layer_count + ADDR_WIDTH'(1);
            end
            if (set_err) begin
                err_code <= err_next;
            end
        end
    end

    // Outputs decoded from the state; the RAM address is masked outside fetches.
    always_comb begin
        bus.ram_en         = (state == S_FETCH_IN) || (state == S_FETCH_OUT);
        bus.ram_addr       = bus.ram_en ? pc[ADDR_WIDTH-1:0] : '0;
        bus.layer_valid    = (state == S_ISSUE);
        bus.layer_in_size  = prev_size;
        bus.layer_out_size = cur_size;
        bus.layer_idx      = idx_q;
        busy               = (state == S_FETCH_IN) || (state == S_FETCH_OUT) ||
                             (state == S_ISSUE);
        done               = (state == S_DONE);
        error              = (state == S_ERROR);
    end

endmodule
